// File: rtl/mips_defines.sv
// Shared MIPS constants: instruction fetch widths, the default instruction ROM depth,
// and the load/run state encoding used by the instruction ROM.
package mips_defines;

  localparam int INST_ADDR_WIDTH = 32;
  localparam int INST_DATA_WIDTH = 32;
  localparam int ROM_DEPTH_LOG2  = 10;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } rom_state_e;

endpackage

// File: rtl/inst_rom_if.sv
// Instruction ROM bus: the core fetch port plus the byte-serial program-load port.
// The slave modport is the ROM; the master modport is the core/loader side.
interface inst_rom_if #(
  parameter int ADDR_WIDTH = mips_defines::INST_ADDR_WIDTH,
  parameter int DATA_WIDTH = mips_defines::INST_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] rom_addr_in;
  logic                  rom_enable_in;
  logic [DATA_WIDTH-1:0] rom_data_out;
  logic                  load_valid;
  logic [7:0]            load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  load_done;
  logic                  core_rst_n;

  modport slave (
    input  rom_addr_in, rom_enable_in, load_valid, load_data, load_last,
    output rom_data_out, load_ready, load_done, core_rst_n
  );

  modport master (
    output rom_addr_in, rom_enable_in, load_valid, load_data, load_last,
    input  rom_data_out, load_ready, load_done, core_rst_n
  );

endinterface

// File: rtl/rom_byte_packer.sv
// Assembles big-endian load bytes into 32-bit words. A word is emitted on its 4th byte,
// or early on the last byte with the unfilled low bytes zeroed.
module rom_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  input  logic        last_in,
  output logic [31:0] word_out,
  output logic        wr_strobe
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] merged;

  always_comb begin
    merged    = {asm_q, byte_in};
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    wr_strobe = accept && (last_in || (cnt_q == 2'd3));
    // Left-justify the bytes gathered so far; a full word needs no shift.
    word_out  = merged << {(2'd3 - cnt_q), 3'b000};
    if (accept) begin
      if (wr_strobe) begin
        cnt_d = 2'd0;
        asm_d = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        asm_d = merged[23:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/inst_rom.sv
// Instruction memory for the MIPS fetch port with a byte-serial program loader that
// holds the core in reset until the program image has been written.
module inst_rom
  import mips_defines::*;
#(
  parameter int DEPTH_LOG2 = ROM_DEPTH_LOG2,
  parameter int ADDR_WIDTH = INST_ADDR_WIDTH,
  parameter int DATA_WIDTH = INST_DATA_WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  inst_rom_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  rom_state_e            state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic                  load_ready_q, load_ready_d;
  logic                  load_done_q, load_done_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic [DATA_WIDTH-1:0] rom_data_q, rom_data_d;

  logic                  accept;
  logic                  wr_strobe;
  logic [31:0]           pack_word;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  rd_oob;

  assign accept = bus.load_valid && load_ready_q;
  assign rd_idx = bus.rom_addr_in[DEPTH_LOG2+1:2];
  // Addresses beyond the memory read as NOP instead of aliasing onto low words.
  assign rd_oob = |(bus.rom_addr_in >> (DEPTH_LOG2 + 2));

  rom_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .byte_in   (bus.load_data),
    .last_in   (bus.load_last),
    .word_out  (pack_word),
    .wr_strobe (wr_strobe)
  );

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    load_ready_d = load_ready_q;
    load_done_d  = 1'b0;
    core_rst_n_d = core_rst_n_q;
    rom_data_d   = '0;
    if (state_q == LOAD) begin
      if (wr_strobe) begin
        wptr_d = wptr_q + 1'b1;
        if (bus.load_last || (wptr_q == '1)) begin
          state_d      = RUN;
          load_ready_d = 1'b0;
          load_done_d  = 1'b1;
          core_rst_n_d = 1'b1;
        end
      end
    end else if (bus.rom_enable_in && !rd_oob) begin
      rom_data_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      wptr_q       <= '0;
      load_ready_q <= 1'b1;
      load_done_q  <= 1'b0;
      core_rst_n_q <= 1'b0;
      rom_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      core_rst_n_q <= core_rst_n_d;
      rom_data_q   <= rom_data_d;
    end
  end

  // Program storage is deliberately left out of reset so a reload only touches the words it writes.
  always_ff @(posedge clk) begin
    if (wr_strobe) begin
      mem[wptr_q] <= DATA_WIDTH'(pack_word);
    end
  end

  assign bus.rom_data_out = rom_data_q;
  assign bus.load_ready   = load_ready_q;
  assign bus.load_done    = load_done_q;
  assign bus.core_rst_n   = core_rst_n_q;

endmodule

// File: tb/tb_inst_rom.sv
// Randomised self-checking bench for inst_rom: a 1024-word and a 4-word instance are
// checked against a byte-list memory model kept in the bench.
module tb_inst_rom;
  import mips_defines::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_rom_if ifb ();
  inst_rom_if ifs ();

  inst_rom u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  inst_rom #(.DEPTH_LOG2(2)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifs.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mdl_big   [1024];
  bit          wr_big    [1024];
  logic [31:0] mdl_small [4];
  bit          wr_small  [4];
  logic [7:0]  load_q [$];

  function automatic int cap_words(bit sm);
    return sm ? 4 : 1024;
  endfunction

  function automatic int dl2(bit sm);
    return sm ? 2 : 10;
  endfunction

  function automatic logic [31:0] get_data(bit sm);
    return sm ? ifs.rom_data_out : ifb.rom_data_out;
  endfunction

  function automatic logic get_ready(bit sm);
    return sm ? ifs.load_ready : ifb.load_ready;
  endfunction

  function automatic logic get_done(bit sm);
    return sm ? ifs.load_done : ifb.load_done;
  endfunction

  function automatic logic get_crst(bit sm);
    return sm ? ifs.core_rst_n : ifb.core_rst_n;
  endfunction

  // Expected fetch result: word (addr / 4) of the program image, NOP when disabled or out of range.
  function automatic logic [31:0] model_read(bit sm, logic [31:0] addr, logic en);
    int idx;
    if (!en) return 32'h0;
    if ((addr >> (dl2(sm) + 2)) != 0) return 32'h0;
    idx = int'(addr >> 2) % cap_words(sm);
    return sm ? mdl_small[idx] : mdl_big[idx];
  endfunction

  // Word w holds bytes 4w..4w+3, first byte most significant, missing bytes zero.
  task automatic model_apply(bit sm, int n_acc, bit commit_partial);
    for (int w = 0; 4 * w < n_acc; w++) begin
      int nb;
      logic [31:0] val;
      nb  = (n_acc - 4 * w) < 4 ? (n_acc - 4 * w) : 4;
      val = 32'h0;
      if (nb == 4 || commit_partial) begin
        for (int b = 0; b < nb; b++) val = val | ({24'h0, load_q[4 * w + b]} << (24 - 8 * b));
        if (sm) begin
          mdl_small[w] = val;
          wr_small[w]  = 1'b1;
        end else begin
          mdl_big[w] = val;
          wr_big[w]  = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_load(bit sm, logic v, logic [7:0] d, logic l);
    if (sm) begin
      ifs.load_valid = v; ifs.load_data = d; ifs.load_last = l;
    end else begin
      ifb.load_valid = v; ifb.load_data = d; ifb.load_last = l;
    end
  endtask

  task automatic drive_fetch(bit sm, logic [31:0] a, logic en);
    if (sm) begin
      ifs.rom_addr_in = a; ifs.rom_enable_in = en;
    end else begin
      ifb.rom_addr_in = a; ifb.rom_enable_in = en;
    end
  endtask

  task automatic do_reset();
    drive_load(0, 0, 8'h0, 0);
    drive_load(1, 0, 8'h0, 0);
    drive_fetch(0, 32'h0, 0);
    drive_fetch(1, 32'h0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_random(int n);
    load_q.delete();
    for (int i = 0; i < n; i++) load_q.push_back(8'($urandom));
  endtask

  // Streams load_q into one instance, checking handshake/reset/done on every accepting edge.
  task automatic load_seq(bit sm, bit last_on_final, bit gaps);
    int n;
    int term;
    int n_acc;
    n    = load_q.size();
    term = -1;
    for (int i = 0; i < n; i++) begin
      if (i == 4 * cap_words(sm) - 1 || (last_on_final && i == n - 1)) begin
        term = i;
        break;
      end
    end
    n_acc = (term >= 0) ? term + 1 : n;
    drive_fetch(sm, 32'h0, 1);
    for (int i = 0; i < n_acc; i++) begin
      logic exp_end;
      exp_end = (i == term);
      if (gaps) begin
        drive_load(sm, 0, 8'($urandom), 1'($urandom));
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drive_load(sm, 1, load_q[i], last_on_final && (i == n - 1));
      @(negedge clk);
      n_cmp++;
      if (get_done(sm) !== exp_end) begin
        n_bad++;
        $display("[TB] FAIL load_done byte %0d: got %b expected %b", i, get_done(sm), exp_end);
      end
      n_cmp++;
      if (get_crst(sm) !== exp_end) begin
        n_bad++;
        $display("[TB] FAIL core_rst_n byte %0d: got %b expected %b", i, get_crst(sm), exp_end);
      end
      n_cmp++;
      if (get_ready(sm) !== !exp_end) begin
        n_bad++;
        $display("[TB] FAIL load_ready byte %0d: got %b expected %b", i, get_ready(sm), !exp_end);
      end
      n_cmp++;
      if (get_data(sm) !== 32'h0) begin
        n_bad++;
        $display("[TB] FAIL fetch_in_load byte %0d: got %h expected 00000000", i, get_data(sm));
      end
    end
    drive_load(sm, 0, 8'h0, 0);
    drive_fetch(sm, 32'h0, 0);
    if (term >= 0) begin
      @(negedge clk);
      n_cmp++;
      if (get_done(sm) !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL load_done_pulse: got %b expected 0", get_done(sm));
      end
      n_cmp++;
      if (get_crst(sm) !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL core_rst_n_hold: got %b expected 1", get_crst(sm));
      end
    end
    model_apply(sm, n_acc, term >= 0);
  endtask

  task automatic fetch_pair(bit sm, logic [31:0] a0, logic [31:0] e0, logic [31:0] a1, logic [31:0] e1);
    drive_fetch(sm, a0, 1);
    @(negedge clk);
    drive_fetch(sm, a1, 1);
    n_cmp++;
    if (get_data(sm) !== e0) begin
      n_bad++;
      $display("[TB] FAIL fetch %h: got %h expected %h", a0, get_data(sm), e0);
    end
    @(negedge clk);
    drive_fetch(sm, 32'h0, 0);
    n_cmp++;
    if (get_data(sm) !== e1) begin
      n_bad++;
      $display("[TB] FAIL fetch %h: got %h expected %h", a1, get_data(sm), e1);
    end
  endtask

  // Back-to-back random fetches in RUN; optionally jiggles the load port, which must be ignored.
  task automatic random_reads(bit sm, int n, bit toggle_load);
    int widx [$];
    for (int i = 0; i < cap_words(sm); i++)
      if (sm ? wr_small[i] : wr_big[i]) widx.push_back(i);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      logic        en;
      logic [31:0] exp;
      int          r;
      r  = $urandom_range(0, 9);
      a  = $urandom;
      en = 1'b1;
      if (r < 7 && widx.size() > 0)
        a = 32'(widx[$urandom_range(0, widx.size() - 1)] * 4 + $urandom_range(0, 3));
      else if (r == 7)
        en = 1'b0;
      else
        a = a | (32'h1 << $urandom_range(dl2(sm) + 2, 31));
      exp = model_read(sm, a, en);
      drive_fetch(sm, a, en);
      if (toggle_load) drive_load(sm, 1'($urandom), 8'($urandom), 1'($urandom));
      @(negedge clk);
      n_cmp++;
      if (get_data(sm) !== exp) begin
        n_bad++;
        $display("[TB] FAIL rand_fetch %h en=%b: got %h expected %h", a, en, get_data(sm), exp);
      end
      if (toggle_load) begin
        n_cmp++;
        if (get_ready(sm) !== 1'b0 || get_done(sm) !== 1'b0 || get_crst(sm) !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL run_load_port: got rdy=%b done=%b crst=%b expected 0 0 1",
                   get_ready(sm), get_done(sm), get_crst(sm));
        end
      end
    end
    drive_fetch(sm, 32'h0, 0);
    drive_load(sm, 0, 8'h0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_load(0, 0, 8'h0, 0);
    drive_load(1, 0, 8'h0, 0);
    drive_fetch(0, 32'h0, 1);
    drive_fetch(1, 32'h0, 1);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if (get_data(s[0]) !== 32'h0) begin
        n_bad++; $display("[TB] FAIL reset_data: got %h expected 00000000", get_data(s[0]));
      end
      n_cmp++;
      if (get_ready(s[0]) !== 1'b1) begin
        n_bad++; $display("[TB] FAIL reset_ready: got %b expected 1", get_ready(s[0]));
      end
      n_cmp++;
      if (get_done(s[0]) !== 1'b0) begin
        n_bad++; $display("[TB] FAIL reset_done: got %b expected 0", get_done(s[0]));
      end
      n_cmp++;
      if (get_crst(s[0]) !== 1'b0) begin
        n_bad++; $display("[TB] FAIL reset_core_rst_n: got %b expected 0", get_crst(s[0]));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    do_reset();
    load_q = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    load_seq(0, 1, 0);
    fetch_pair(0, 32'h0, 32'h34011100, 32'h4, 32'h34020020);
  endtask

  task automatic test_partial_word();
    do_reset();
    load_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    load_seq(0, 1, 0);
    fetch_pair(0, 32'h6, 32'hEEFF0000, 32'h3, 32'hAABBCCDD);
  endtask

  task automatic test_full_small();
    int pulses;
    do_reset();
    fill_random(16);
    load_seq(1, 0, 0);
    drive_load(1, 1, 8'h5A, 0);
    @(negedge clk);
    n_cmp++;
    if (get_ready(1) !== 1'b0 || get_done(1) !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL extra_byte: got rdy=%b done=%b expected 0 0", get_ready(1), get_done(1));
    end
    drive_load(1, 0, 8'h0, 0);
    fetch_pair(1, 32'h10, 32'h0, 32'hC, model_read(1, 32'hC, 1));
    random_reads(1, 20, 0);
    do_reset();
    fill_random(16);
    load_seq(1, 1, 0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (get_done(1) === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++; $display("[TB] FAIL full_and_last_pulses: got %0d extra expected 0", pulses);
    end
    random_reads(1, 12, 0);
  endtask

  task automatic test_enable_gating();
    do_reset();
    fill_random(40);
    load_seq(0, 1, 1);
    drive_fetch(0, 32'h0, 0);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (get_data(0) !== 32'h0) begin
        n_bad++; $display("[TB] FAIL disabled_fetch: got %h expected 00000000", get_data(0));
      end
    end
    random_reads(0, 60, 1);
  endtask

  task automatic test_abort_reload();
    do_reset();
    fill_random(5);
    load_seq(0, 0, 0);
    do_reset();
    n_cmp++;
    if (get_crst(0) !== 1'b0) begin
      n_bad++; $display("[TB] FAIL abort_core_rst_n: got %b expected 0", get_crst(0));
    end
    load_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_seq(0, 1, 0);
    fetch_pair(0, 32'h0, 32'h12345678, 32'h4, model_read(0, 32'h4, 1));
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_random(22);
    load_seq(0, 1, 0);
    random_reads(0, 30, 0);
    do_reset();
    load_seq(0, 1, 1);
    random_reads(0, 30, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_partial_word();
    test_full_small();
    test_enable_gating();
    test_abort_reload();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
